cpu_run_controller: RTL and testbench
=====================================

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 SHALL have parameter NCPU, default 2: number of CPU channels monitored in parallel (1..8).
REQ-002 SHALL have parameter DATA_W, default 32: width of each register_v0 value.
REQ-003 SHALL have parameter RESET_CYCLES, default 2: cycles cpu_reset is held high after start (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 500: maximum enabled RUN cycles before timeout (>=1).
REQ-005 SHALL have parameter CNT_W, default 16: cycle counter width.
REQ-006 SHALL have parameter STALL_PERIOD, default 0: 0 = clock enable always high in RUN; N>=2 = clock enable low one cycle in every N.
REQ-007 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  begin a run; sampled in IDLE or DONE only.
REQ-010 abort  in  1  cancel run, return to IDLE.
REQ-011 expected  in  NCPU*DATA_W  expected register_v0 per channel, slice i = channel i.
REQ-012 cpu_active  in  NCPU  per-channel CPU active flag.
REQ-013 cpu_v0  in  NCPU*DATA_W  per-channel register_v0.
REQ-014 cpu_reset  out  1  active-high reset to all CPUs.
REQ-015 cpu_clock_enable  out  1  clock enable to all CPUs.
REQ-016 busy, done  out  1 each  run in progress / run finished (level).
REQ-017 pass_mask, timeout_mask  out  NCPU each  per-channel result flags.
REQ-018 result  out  NCPU*DATA_W  captured cpu_v0 per channel.
REQ-019 cycles  out  CNT_W  enabled RUN cycles consumed by the run.

Function
REQ-020 SHALL implement FSM IDLE, RESET, RUN, DONE; all outputs registered.
REQ-021 IDLE: cpu_reset=1, cpu_clock_enable=0, busy=0, done=0; start -> RESET.
REQ-022 Entering RESET SHALL clear result, pass_mask, timeout_mask, cycles, finished flags, stall counter; busy=1, done=0.
REQ-023 RESET: cpu_reset=1, cpu_clock_enable=1 for exactly RESET_CYCLES cycles, then -> RUN.
REQ-024 RUN: cpu_reset=0; cpu_clock_enable per REQ-025; cpu_active ignored outside RUN.
REQ-025 STALL_PERIOD=N>=2: stall counter counts 0..N-1 and wraps; cpu_clock_enable=0 when counter=N-1, else 1.
REQ-026 Only RUN cycles with cpu_clock_enable=1 are enabled cycles; cycles increments on each, saturating at 2^CNT_W-1.
REQ-027 On an enabled cycle where cpu_active[i]=0 and channel i not finished: result[i]<=cpu_v0[i], pass_mask[i]<=(cpu_v0[i]==expected[i]), finished[i] set; later samples of channel i ignored.
REQ-028 When all channels finished -> DONE on the same edge that finishes the last channel.
REQ-029 When the enabled cycle that brings cycles to TIMEOUT_CYCLES completes, every still-unfinished channel gets timeout_mask=1, result=0, pass_mask=0; -> DONE.
REQ-030 A channel finishing on the timeout cycle SHALL count as finished, not timed out.
REQ-031 DONE: done=1, busy=0, cpu_clock_enable=0, cpu_reset=0; all results held; start -> RESET.
REQ-032 start while in RESET or RUN SHALL be ignored.
REQ-033 abort in RESET, RUN or DONE -> IDLE next edge, clearing done and all masks; abort has priority over start.

Reset
REQ-034 reset low SHALL immediately force IDLE: cpu_reset=1, cpu_clock_enable=0, busy=0, done=0, masks=0, result=0, cycles=0, irrespective of clk; applies mid-run too.
REQ-035 After reset release, no run starts until start is sampled high.

Verification (NCPU=2, RESET_CYCLES=2, TIMEOUT_CYCLES=10, STALL_PERIOD=0 unless stated)
REQ-036 Pass: start; ch0 active low on RUN cycle 4 with v0=0x11, ch1 on cycle 6 with v0=0x22, expected {0x22,0x11} -> done, pass_mask=2'b11, timeout_mask=0, cycles=6.
REQ-037 Mismatch+timeout: ch0 finishes cycle 3 with v0=0x5 (expected 0x7), ch1 never -> pass_mask=0, timeout_mask=2'b10, result[1]=0, cycles=10.
REQ-038 Boundary: ch1 finishes exactly on cycle 10 -> timeout_mask[1]=0, finished with captured value.
REQ-039 Stall: STALL_PERIOD=3, ch0/ch1 finish on 4th enabled cycle -> cpu_clock_enable pattern 1,1,0,1,1 in RUN, cycles=4, done after 5 RUN clock cycles.
REQ-040 Async reset asserted mid-RUN between clock edges -> outputs at IDLE values before next edge; abort+start same cycle in RUN -> IDLE.

Source files
------------

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences a batch of CPU test runs: holds the CPUs in reset, releases them,
// watches each channel until its CPU drops cpu_active_i, captures register_v0,
// and compares it against the expected value. Channels that are still active
// when the cycle budget runs out are flagged as timed out.
//
// Ports
//   clk_i               single clock, rising edge
//   rst_ni              asynchronous active-low reset (forces IDLE at once)
//   start_i             begin a run (honoured in IDLE or DONE only)
//   abort_i             cancel a run / clear results, return to IDLE
//   expected_i          expected register_v0, slice i = channel i
//   cpu_active_i        per-channel CPU active flag
//   cpu_v0_i            per-channel register_v0, slice i = channel i
//   cpu_reset_o         active-high reset to all CPUs
//   cpu_clock_enable_o  clock enable to all CPUs
//   busy_o / done_o     run in progress / run finished (levels)
//   pass_mask_o         per-channel compare result
//   timeout_mask_o      per-channel timeout flag
//   result_o            captured register_v0 per channel
//   cycles_o            enabled RUN cycles consumed by the run
module cpu_run_controller #(
    parameter int NCPU           = 2,
    parameter int DATA_W         = 32,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int CNT_W          = 16,
    parameter int STALL_PERIOD   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [NCPU*DATA_W-1:0] expected_i,
    input  logic [NCPU-1:0]        cpu_active_i,
    input  logic [NCPU*DATA_W-1:0] cpu_v0_i,
    output logic                   cpu_reset_o,
    output logic                   cpu_clock_enable_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NCPU-1:0]        pass_mask_o,
    output logic [NCPU-1:0]        timeout_mask_o,
    output logic [NCPU*DATA_W-1:0] result_o,
    output logic [CNT_W-1:0]       cycles_o
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SP_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);
    localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(STALL_PERIOD - 1);
    localparam logic [CNT_W:0]   TMO_LIM  = (CNT_W+1)'(TIMEOUT_CYCLES);
    localparam bit               STALL_ON = (STALL_PERIOD >= 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic [SP_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]       cycles_q, cycles_d;
    logic [NCPU-1:0]        finished_q, finished_d;
    logic [NCPU-1:0]        pass_q, pass_d;
    logic [NCPU-1:0]        tmo_q, tmo_d;
    logic [NCPU*DATA_W-1:0] result_q, result_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   cke_q, cke_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   en_cycle;
    logic [NCPU-1:0]        fin_now;
    logic [NCPU-1:0]        v0_match;
    logic [CNT_W:0]         cycles_inc;

    // An enabled cycle is a RUN cycle in which the CPUs actually got a clock.
    assign en_cycle   = (state_q == S_RUN) && cke_q;
    assign cycles_inc = {1'b0, cycles_q} + {{CNT_W{1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < NCPU; gi++) begin : g_ch
            assign fin_now[gi]  = en_cycle & ~cpu_active_i[gi] & ~finished_q[gi];
            assign v0_match[gi] = (cpu_v0_i[gi*DATA_W +: DATA_W] ==
                                   expected_i[gi*DATA_W +: DATA_W]);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        cycles_d    = cycles_q;
        finished_d  = finished_q;
        pass_d      = pass_q;
        tmo_d       = tmo_q;
        result_d    = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_RESET;
                end
            end
            S_RESET: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (rst_cnt_q == RC_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (STALL_ON) begin
                        stall_cnt_d = (stall_cnt_q == SP_LAST) ? '0 : stall_cnt_q + 1'b1;
                    end
                    if (cke_q) begin
                        cycles_d   = cycles_inc[CNT_W] ? cycles_q : cycles_inc[CNT_W-1:0];
                        finished_d = finished_q | fin_now;
                        pass_d     = pass_q | (fin_now & v0_match);
                        for (int i = 0; i < NCPU; i++) begin
                            if (fin_now[i]) begin
                                result_d[i*DATA_W +: DATA_W] = cpu_v0_i[i*DATA_W +: DATA_W];
                            end
                        end
                        // A channel finishing on the last budgeted cycle still
                        // counts as finished, hence the test on finished_d.
                        if (&finished_d) begin
                            state_d = S_DONE;
                        end else if (cycles_inc >= TMO_LIM) begin
                            tmo_d   = ~finished_d;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (start_i) begin
                    state_d = S_RESET;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort leaves results readable but clears the status flags.
        if (state_q != S_IDLE && state_d == S_IDLE) begin
            pass_d = '0;
            tmo_d  = '0;
        end

        // Fresh run: wipe everything left over from the previous one.
        if (state_q != S_RESET && state_d == S_RESET) begin
            rst_cnt_d   = '0;
            stall_cnt_d = '0;
            cycles_d    = '0;
            finished_d  = '0;
            pass_d      = '0;
            tmo_d       = '0;
            result_d    = '0;
        end

        // Outputs are registered, so they are derived from the next state.
        cpu_reset_d = (state_d == S_IDLE) || (state_d == S_RESET);
        busy_d      = (state_d == S_RESET) || (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
        cke_d       = (state_d == S_RESET) ||
                      ((state_d == S_RUN) && (!STALL_ON || (stall_cnt_d != SP_LAST)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            stall_cnt_q <= '0;
            cycles_q    <= '0;
            finished_q  <= '0;
            pass_q      <= '0;
            tmo_q       <= '0;
            result_q    <= '0;
            cpu_reset_q <= 1'b1;
            cke_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            cycles_q    <= cycles_d;
            finished_q  <= finished_d;
            pass_q      <= pass_d;
            tmo_q       <= tmo_d;
            result_q    <= result_d;
            cpu_reset_q <= cpu_reset_d;
            cke_q       <= cke_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cpu_reset_o        = cpu_reset_q;
    assign cpu_clock_enable_o = cke_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign pass_mask_o        = pass_q;
    assign timeout_mask_o     = tmo_q;
    assign result_o           = result_q;
    assign cycles_o           = cycles_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: one instance without stalls and one
// with STALL_PERIOD=3, both with NCPU=2, RESET_CYCLES=2, TIMEOUT_CYCLES=10.
module tb_cpu_run_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] expected = '0;
    logic [1:0]  cpu_active = 2'b11;
    logic [63:0] cpu_v0 = '0;

    logic        cpu_reset, cke, busy, done;
    logic [1:0]  pass_mask, tmo_mask;
    logic [63:0] result;
    logic [15:0] cycles;

    logic        cpu_reset_s, cke_s, busy_s, done_s;
    logic [1:0]  pass_mask_s, tmo_mask_s;
    logic [63:0] result_s;
    logic [15:0] cycles_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .NCPU(2), .DATA_W(32), .RESET_CYCLES(2), .TIMEOUT_CYCLES(10),
        .CNT_W(16), .STALL_PERIOD(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .expected_i(expected), .cpu_active_i(cpu_active), .cpu_v0_i(cpu_v0),
        .cpu_reset_o(cpu_reset), .cpu_clock_enable_o(cke), .busy_o(busy),
        .done_o(done), .pass_mask_o(pass_mask), .timeout_mask_o(tmo_mask),
        .result_o(result), .cycles_o(cycles)
    );

    cpu_run_controller #(
        .NCPU(2), .DATA_W(32), .RESET_CYCLES(2), .TIMEOUT_CYCLES(10),
        .CNT_W(16), .STALL_PERIOD(3)
    ) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s), .abort_i(abort),
        .expected_i(expected), .cpu_active_i(cpu_active), .cpu_v0_i(cpu_v0),
        .cpu_reset_o(cpu_reset_s), .cpu_clock_enable_o(cke_s), .busy_o(busy_s),
        .done_o(done_s), .pass_mask_o(pass_mask_s), .timeout_mask_o(tmo_mask_s),
        .result_o(result_s), .cycles_o(cycles_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then step through the two RESET cycles; returns in RUN cycle 1.
    task automatic enter_run(input bit use_stall);
        if (use_stall) start_s = 1'b1; else start = 1'b1;
        tick;
        start   = 1'b0;
        start_s = 1'b0;
        if (use_stall) begin
            check("reset_busy_s", busy_s, 1'b1);
        end else begin
            check("reset_busy", busy, 1'b1);
            check("reset_cpu_reset", cpu_reset, 1'b1);
            check("reset_cke", cke, 1'b1);
            check("reset_cleared", {pass_mask, tmo_mask, cycles}, '0);
        end
        tick;
        tick;
    endtask

    initial begin
        // Power-on reset
        #12;
        check("por_outputs", {cpu_reset, cke, busy, done}, 4'b1000);
        check("por_masks", {pass_mask, tmo_mask, cycles}, '0);
        rst_n = 1'b1;
        repeat (3) tick;
        check("idle_no_autostart", {busy, cpu_reset}, 2'b01);

        // Both channels pass; start pulsed in RUN must be ignored
        expected = {32'h22, 32'h11};
        enter_run(1'b0);
        check("t1_run_outputs", {cpu_reset, cke}, 2'b01);
        for (int k = 1; k <= 6; k++) begin
            cpu_active = 2'b11;
            cpu_v0     = {32'hBB, 32'hAA};
            if (k >= 4) cpu_active[0] = 1'b0;
            if (k == 4) cpu_v0[31:0] = 32'h11;
            if (k == 6) begin
                cpu_active[1] = 1'b0;
                cpu_v0[63:32] = 32'h22;
            end
            start = (k == 2);
            tick;
            if (k == 5) check("t1_mid_status", {busy, done}, 2'b10);
        end
        start = 1'b0;
        cpu_active = 2'b11;
        check("t1_status", {busy, done, cke, cpu_reset}, 4'b0100);
        check("t1_pass", pass_mask, 2'b11);
        check("t1_tmo", tmo_mask, 2'b00);
        check("t1_cycles", cycles, 16'd6);
        check("t1_result", result, {32'h22, 32'h11});
        $display("transaction pass_run: pass=%b tmo=%b cycles=%0d", pass_mask, tmo_mask, cycles);

        // Mismatch on ch0, ch1 times out; started from DONE
        expected = {32'h33, 32'h7};
        enter_run(1'b0);
        for (int k = 1; k <= 10; k++) begin
            cpu_active = 2'b11;
            cpu_v0     = {32'hCC, 32'hDD};
            if (k == 3) begin
                cpu_active[0] = 1'b0;
                cpu_v0[31:0]  = 32'h5;
            end
            tick;
            if (k == 9) check("t2_before_tmo", {done, tmo_mask}, 3'b000);
        end
        cpu_active = 2'b11;
        check("t2_done", done, 1'b1);
        check("t2_pass", pass_mask, 2'b00);
        check("t2_tmo", tmo_mask, 2'b10);
        check("t2_result", result, {32'h0, 32'h5});
        check("t2_cycles", cycles, 16'd10);
        $display("transaction timeout_run: pass=%b tmo=%b cycles=%0d", pass_mask, tmo_mask, cycles);

        // ch1 finishes on exactly the timeout cycle
        expected = {32'h44, 32'h7};
        enter_run(1'b0);
        for (int k = 1; k <= 10; k++) begin
            cpu_active = 2'b11;
            cpu_v0     = {32'hEE, 32'hFF};
            if (k == 2) begin
                cpu_active[0] = 1'b0;
                cpu_v0[31:0]  = 32'h7;
            end
            if (k == 10) begin
                cpu_active[1] = 1'b0;
                cpu_v0[63:32] = 32'h44;
            end
            tick;
        end
        cpu_active = 2'b11;
        check("t3_done", done, 1'b1);
        check("t3_tmo", tmo_mask, 2'b00);
        check("t3_pass", pass_mask, 2'b11);
        check("t3_result", result, {32'h44, 32'h7});
        check("t3_cycles", cycles, 16'd10);
        $display("transaction boundary_run: pass=%b tmo=%b cycles=%0d", pass_mask, tmo_mask, cycles);

        // Abort from DONE clears done and masks
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_done_status", {busy, done, cpu_reset, cke}, 4'b0010);
        check("abort_done_masks", {pass_mask, tmo_mask}, 4'b0000);
        $display("transaction abort_from_done: done=%b", done);

        // Abort and start together in RUN: abort wins
        enter_run(1'b0);
        tick;
        tick;
        abort = 1'b1;
        start = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        check("abort_run_status", {busy, done, cpu_reset, cke}, 4'b0010);
        tick;
        check("abort_run_stays_idle", busy, 1'b0);
        $display("transaction abort_in_run: busy=%b", busy);

        // Stalled instance: enable pattern 1,1,0,1,1; stall-cycle sample ignored
        expected = {32'h66, 32'h55};
        enter_run(1'b1);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("t4_cke_run%0d", k), cke_s, (k == 3) ? 1'b0 : 1'b1);
            cpu_active = 2'b11;
            cpu_v0     = {32'h1, 32'h2};
            if (k == 3) cpu_active = 2'b00;
            if (k == 5) begin
                cpu_active = 2'b00;
                cpu_v0     = {32'h66, 32'h55};
            end
            tick;
            if (k == 4) check("t4_not_done", done_s, 1'b0);
        end
        cpu_active = 2'b11;
        check("t4_done", {done_s, busy_s, cke_s}, 3'b100);
        check("t4_cycles", cycles_s, 16'd4);
        check("t4_pass", pass_mask_s, 2'b11);
        check("t4_result", result_s, {32'h66, 32'h55});
        $display("transaction stall_run: cycles=%0d pass=%b", cycles_s, pass_mask_s);

        // Asynchronous reset between edges mid-RUN
        expected = {32'h22, 32'h11};
        enter_run(1'b0);
        tick;
        tick;
        tick;
        check("t5_cycles_before", cycles, 16'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_status", {cpu_reset, cke, busy, done}, 4'b1000);
        check("t5_async_regs", {pass_mask, tmo_mask, cycles}, '0);
        check("t5_async_result", result, '0);
        #10 rst_n = 1'b1;
        repeat (3) tick;
        check("t5_no_autostart", {busy, cpu_reset}, 2'b01);
        $display("transaction async_reset: busy=%b cpu_reset=%b", busy, cpu_reset);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
